// File: rtl/rf_cmd_seq.sv
// rf_cmd_seq: decodes 16-bit commands into dual-bank register-file port activity.
// Define RF_CMD_SEQ_CNT_EN to add the saturating wr_count/rd_count statistics outputs.
module rf_cmd_seq #(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic        rf_start,
  output logic [2:0]  rf_write_reg_a,
  output logic [3:0]  rf_write_data_a,
  output logic        rf_write_en_a,
  output logic [2:0]  rf_read_reg_a1,
  output logic [2:0]  rf_read_reg_a2,
  output logic [3:0]  rf_write_reg_b,
  output logic [7:0]  rf_write_data_b,
  output logic        rf_write_en_b,
  output logic [3:0]  rf_read_reg_b,
  input  logic [3:0]  rf_out1,
  input  logic [3:0]  rf_out2,
  output logic [3:0]  rd_data1,
  output logic [3:0]  rd_data2,
  output logic        rd_valid
`ifdef RF_CMD_SEQ_CNT_EN
  ,
  output logic [7:0]  wr_count,
  output logic [7:0]  rd_count
`endif
);

  typedef enum logic [1:0] {IDLE, WR, RD_WAIT} stateT;

  localparam logic [2:0] LAT = 3'(READ_LAT);

  stateT      state;
  logic [2:0] waitCnt;
  logic       accept;
  logic [1:0] opcode;

  assign cmd_ready = (state == IDLE) && rf_start;
  assign accept    = cmd_valid && cmd_ready;
  assign opcode    = cmd_data[15:14];

  // Addresses and data hold after a transaction; only enables and strobes drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      waitCnt         <= 3'd0;
      rf_start        <= 1'b0;
      rf_write_reg_a  <= 3'd0;
      rf_write_data_a <= 4'd0;
      rf_write_en_a   <= 1'b0;
      rf_read_reg_a1  <= 3'd0;
      rf_read_reg_a2  <= 3'd0;
      rf_write_reg_b  <= 4'd0;
      rf_write_data_b <= 8'd0;
      rf_write_en_b   <= 1'b0;
      rf_read_reg_b   <= 4'd0;
      rd_data1        <= 4'd0;
      rd_data2        <= 4'd0;
      rd_valid        <= 1'b0;
    end else begin
      rf_start <= 1'b1;
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (opcode)
              2'b01: begin
                rf_write_reg_a  <= cmd_data[13:11];
                rf_write_data_a <= cmd_data[3:0];
                rf_write_en_a   <= 1'b1;
                state           <= WR;
              end
              2'b10: begin
                rf_write_reg_b  <= cmd_data[13:10];
                rf_write_data_b <= cmd_data[7:0];
                rf_write_en_b   <= 1'b1;
                state           <= WR;
              end
              2'b11: begin
                rf_read_reg_a1 <= cmd_data[13:11];
                rf_read_reg_a2 <= cmd_data[10:8];
                rf_read_reg_b  <= cmd_data[7:4];
                waitCnt        <= 3'd0;
                state          <= RD_WAIT;
              end
              default: ;
            endcase
          end
        end
        WR: begin
          rf_write_en_a <= 1'b0;
          rf_write_en_b <= 1'b0;
          state         <= IDLE;
        end
        RD_WAIT: begin
          if (waitCnt == LAT) begin
            rd_data1 <= rf_out1;
            rd_data2 <= rf_out2;
            rd_valid <= 1'b1;
            state    <= IDLE;
          end else begin
            waitCnt <= waitCnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RF_CMD_SEQ_CNT_EN
  // Statistics saturate at 255 so long runs never wrap back to small values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count <= 8'd0;
      rd_count <= 8'd0;
    end else begin
      if ((rf_write_en_a || rf_write_en_b) && (wr_count != 8'hFF))
        wr_count <= wr_count + 8'd1;
      if (rd_valid && (rd_count != 8'hFF))
        rd_count <= rd_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rf_cmd_seq.sv
// tb_rf_cmd_seq: three sequencers (READ_LAT 0, 1, 3) each with its own register-file
// model, checked every cycle against a transaction-level busy/latency model.
module tb_rf_cmd_seq;

  localparam int NL = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] cmdData [NL];
  logic        cmdValid [NL];
  logic        cmdReady [NL];
  logic        rfStart [NL];
  logic [2:0]  wrRegA [NL];
  logic [3:0]  wrDataA [NL];
  logic        wrEnA [NL];
  logic [2:0]  rdRegA1 [NL];
  logic [2:0]  rdRegA2 [NL];
  logic [3:0]  wrRegB [NL];
  logic [7:0]  wrDataB [NL];
  logic        wrEnB [NL];
  logic [3:0]  rdRegB [NL];
  logic [3:0]  rdData1 [NL];
  logic [3:0]  rdData2 [NL];
  logic        rdValid [NL];
`ifdef RF_CMD_SEQ_CNT_EN
  logic [7:0]  wrCount [NL];
  logic [7:0]  rdCount [NL];
`endif

  for (genvar g = 0; g < NL; g++) begin : lane
    logic [3:0] memA [8] = '{default: 4'h0};
    logic [3:0] regOut1, regOut2, out1, out2;

    rf_cmd_seq #(.READ_LAT((g == 0) ? 0 : (g == 1) ? 1 : 3)) dut (
      .clk(clk), .rst(rst),
      .cmd_data(cmdData[g]), .cmd_valid(cmdValid[g]), .cmd_ready(cmdReady[g]),
      .rf_start(rfStart[g]),
      .rf_write_reg_a(wrRegA[g]), .rf_write_data_a(wrDataA[g]), .rf_write_en_a(wrEnA[g]),
      .rf_read_reg_a1(rdRegA1[g]), .rf_read_reg_a2(rdRegA2[g]),
      .rf_write_reg_b(wrRegB[g]), .rf_write_data_b(wrDataB[g]), .rf_write_en_b(wrEnB[g]),
      .rf_read_reg_b(rdRegB[g]),
      .rf_out1(out1), .rf_out2(out2),
`ifdef RF_CMD_SEQ_CNT_EN
      .wr_count(wrCount[g]), .rd_count(rdCount[g]),
`endif
      .rd_data1(rdData1[g]), .rd_data2(rdData2[g]), .rd_valid(rdValid[g])
    );

    // Lane 0 models a combinational-read file, the others a registered-read file.
    always @(posedge clk) begin
      if (wrEnA[g]) memA[wrRegA[g]] <= wrDataA[g];
      regOut1 <= memA[rdRegA1[g]];
      regOut2 <= memA[rdRegA2[g]];
    end
    assign out1 = (g == 0) ? memA[rdRegA1[g]] : regOut1;
    assign out2 = (g == 0) ? memA[rdRegA2[g]] : regOut2;
  end

  int total = 0;
  int bad = 0;

  logic       mStart [NL];
  int         mBusy [NL];
  int         mReadLeft [NL];
  logic       mWeA [NL], mWeB [NL], mRdValid [NL];
  logic [2:0] mWa [NL], mRa1 [NL], mRa2 [NL];
  logic [3:0] mWda [NL], mWb [NL], mRb [NL], mRd1 [NL], mRd2 [NL];
  logic [7:0] mWdb [NL];
  logic [3:0] mMemA [NL][8];
  int         mWrCnt [NL], mRdCnt [NL];
  logic       acc [NL];

  function automatic int latOf(input int l);
    return (l == 0) ? 0 : (l == 1) ? 1 : 3;
  endfunction

  task automatic checkVal(input string name, input int l, input logic [15:0] act,
                          input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s lane%0d: got %h expected %h at %0t", name, l, act, exp, $time);
    end
  endtask

  task automatic modelReset(input int l);
    mStart[l] = 1'b0; mBusy[l] = 0; mReadLeft[l] = 0;
    mWeA[l] = 1'b0; mWeB[l] = 1'b0; mRdValid[l] = 1'b0;
    mWa[l] = '0; mRa1[l] = '0; mRa2[l] = '0; mWda[l] = '0; mWb[l] = '0;
    mRb[l] = '0; mRd1[l] = '0; mRd2[l] = '0; mWdb[l] = '0;
    mWrCnt[l] = 0; mRdCnt[l] = 0; acc[l] = 1'b0;
  endtask

  // Predicts the outputs after the coming rising edge from the inputs now applied.
  task automatic modelStep();
    for (int l = 0; l < NL; l++) begin
      if (rst) begin
        modelReset(l);
      end else begin
        acc[l] = cmdValid[l] && mStart[l] && (mBusy[l] == 0);
        if (mWeA[l]) mMemA[l][mWa[l]] = mWda[l];
        if ((mWeA[l] || mWeB[l]) && mWrCnt[l] < 255) mWrCnt[l]++;
        if (mRdValid[l] && mRdCnt[l] < 255) mRdCnt[l]++;
        mStart[l] = 1'b1;
        mWeA[l] = 1'b0; mWeB[l] = 1'b0; mRdValid[l] = 1'b0;
        if (mBusy[l] > 0) mBusy[l]--;
        if (mReadLeft[l] > 0) begin
          mReadLeft[l]--;
          if (mReadLeft[l] == 0) begin
            mRdValid[l] = 1'b1;
            mRd1[l] = mMemA[l][mRa1[l]];
            mRd2[l] = mMemA[l][mRa2[l]];
          end
        end
        if (acc[l]) begin
          case (cmdData[l][15:14])
            2'b01: begin
              mWa[l] = cmdData[l][13:11]; mWda[l] = cmdData[l][3:0];
              mWeA[l] = 1'b1; mBusy[l] = 1;
            end
            2'b10: begin
              mWb[l] = cmdData[l][13:10]; mWdb[l] = cmdData[l][7:0];
              mWeB[l] = 1'b1; mBusy[l] = 1;
            end
            2'b11: begin
              mRa1[l] = cmdData[l][13:11]; mRa2[l] = cmdData[l][10:8]; mRb[l] = cmdData[l][7:4];
              mBusy[l] = latOf(l) + 1; mReadLeft[l] = latOf(l) + 1;
            end
            default: ;
          endcase
        end
      end
    end
  endtask

  task automatic checkOutput();
    for (int l = 0; l < NL; l++) begin
      checkVal("cmd_ready", l, 16'(cmdReady[l]), 16'(mStart[l] && (mBusy[l] == 0)));
      checkVal("rf_start", l, 16'(rfStart[l]), 16'(mStart[l]));
      checkVal("we_a", l, 16'(wrEnA[l]), 16'(mWeA[l]));
      checkVal("wreg_a", l, 16'(wrRegA[l]), 16'(mWa[l]));
      checkVal("wdata_a", l, 16'(wrDataA[l]), 16'(mWda[l]));
      checkVal("we_b", l, 16'(wrEnB[l]), 16'(mWeB[l]));
      checkVal("wreg_b", l, 16'(wrRegB[l]), 16'(mWb[l]));
      checkVal("wdata_b", l, 16'(wrDataB[l]), 16'(mWdb[l]));
      checkVal("rreg_a1", l, 16'(rdRegA1[l]), 16'(mRa1[l]));
      checkVal("rreg_a2", l, 16'(rdRegA2[l]), 16'(mRa2[l]));
      checkVal("rreg_b", l, 16'(rdRegB[l]), 16'(mRb[l]));
      checkVal("rd_valid", l, 16'(rdValid[l]), 16'(mRdValid[l]));
      checkVal("rd_data1", l, 16'(rdData1[l]), 16'(mRd1[l]));
      checkVal("rd_data2", l, 16'(rdData2[l]), 16'(mRd2[l]));
`ifdef RF_CMD_SEQ_CNT_EN
      checkVal("wr_count", l, 16'(wrCount[l]), 16'(mWrCnt[l]));
      checkVal("rd_count", l, 16'(rdCount[l]), 16'(mRdCnt[l]));
`endif
    end
  endtask

  task automatic cycle();
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic applyStimulus();
    for (int l = 0; l < NL; l++) begin
      if (!cmdValid[l] || acc[l]) begin
        cmdValid[l] = ($urandom_range(3) != 0);
        cmdData[l]  = 16'($urandom);
      end
    end
  endtask

  task automatic sendAll(input logic [15:0] cmd);
    logic done [NL];
    bit allDone;
    for (int l = 0; l < NL; l++) begin
      cmdValid[l] = 1'b1; cmdData[l] = cmd; done[l] = 1'b0;
    end
    allDone = 1'b0;
    for (int n = 0; n < 20 && !allDone; n++) begin
      cycle();
      allDone = 1'b1;
      for (int l = 0; l < NL; l++) begin
        if (acc[l]) begin
          done[l] = 1'b1; cmdValid[l] = 1'b0;
        end
        if (!done[l]) allDone = 1'b0;
      end
    end
    for (int l = 0; l < NL; l++) checkVal("accept_timeout", l, 16'(done[l]), 16'd1);
  endtask

  // Rising-edge count from acceptance to the rd_valid strobe, and captured data.
  task automatic readBack(input string tag);
    int pulses [NL];
    int edges [NL];
    logic [3:0] d1 [NL];
    logic [3:0] d2 [NL];
    sendAll(16'hDD60);
    for (int l = 0; l < NL; l++) begin
      pulses[l] = 0; edges[l] = 0; d1[l] = 4'h0; d2[l] = 4'h0;
    end
    for (int n = 1; n <= 6; n++) begin
      cycle();
      for (int l = 0; l < NL; l++) begin
        if (rdValid[l] === 1'b1) begin
          pulses[l]++; edges[l] = n; d1[l] = rdData1[l]; d2[l] = rdData2[l];
        end
      end
    end
    for (int l = 0; l < NL; l++) begin
      checkVal({tag, "_pulses"}, l, 16'(pulses[l]), 16'd1);
      checkVal({tag, "_edges"}, l, 16'(edges[l]), (l == 0) ? 16'd1 : (l == 1) ? 16'd2 : 16'd4);
      checkVal({tag, "_d1"}, l, 16'(d1[l]), 16'hF);
      checkVal({tag, "_d2"}, l, 16'(d2[l]), 16'h8);
      checkVal({tag, "_ra1"}, l, 16'(rdRegA1[l]), 16'd3);
      checkVal({tag, "_ra2"}, l, 16'(rdRegA2[l]), 16'd5);
      checkVal({tag, "_rb"}, l, 16'(rdRegB[l]), 16'd6);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int l = 0; l < NL; l++) begin
      cmdValid[l] = 1'b1; cmdData[l] = 16'h580F;
      modelReset(l);
      for (int i = 0; i < 8; i++) mMemA[l][i] = 4'h0;
    end
    @(negedge clk);
    checkOutput();
    repeat (2) cycle();
    for (int l = 0; l < NL; l++) begin
      checkVal("rst_start", l, 16'(rfStart[l]), 16'd0);
      checkVal("rst_ready", l, 16'(cmdReady[l]), 16'd0);
      checkVal("rst_we_a", l, 16'(wrEnA[l]), 16'd0);
    end
    rst = 1'b0;
    cycle();
    for (int l = 0; l < NL; l++) begin
      checkVal("post_rst_start", l, 16'(rfStart[l]), 16'd1);
      checkVal("post_rst_ready", l, 16'(cmdReady[l]), 16'd1);
    end

    sendAll(16'h580F);
    for (int l = 0; l < NL; l++) begin
      checkVal("wa_en", l, 16'(wrEnA[l]), 16'd1);
      checkVal("wa_addr", l, 16'(wrRegA[l]), 16'd3);
      checkVal("wa_data", l, 16'(wrDataA[l]), 16'hF);
      checkVal("wa_busy", l, 16'(cmdReady[l]), 16'd0);
    end
    sendAll(16'h90FF);
    for (int l = 0; l < NL; l++) begin
      checkVal("wb_en", l, 16'(wrEnB[l]), 16'd1);
      checkVal("wb_addr", l, 16'(wrRegB[l]), 16'd4);
      checkVal("wb_data", l, 16'(wrDataB[l]), 16'hFF);
    end
    sendAll(16'h6808);
    sendAll(16'h980A);
    cycle();
    readBack("read1");

    sendAll(16'h0000);
    for (int l = 0; l < NL; l++) begin
      checkVal("nop_ready", l, 16'(cmdReady[l]), 16'd1);
      checkVal("nop_we", l, 16'(wrEnA[l] | wrEnB[l]), 16'd0);
    end

    sendAll(16'hDD60);
    rst = 1'b1;
    cycle();
    cycle();
    for (int l = 0; l < NL; l++) begin
      checkVal("midrst_valid", l, 16'(rdValid[l]), 16'd0);
      checkVal("midrst_ra1", l, 16'(rdRegA1[l]), 16'd0);
    end
    rst = 1'b0;
    cycle();
    readBack("read2");

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) rst = 1'b1;
      if (i == 1502) rst = 1'b0;
      applyStimulus();
      cycle();
    end
    rst = 1'b0;
    for (int l = 0; l < NL; l++) cmdValid[l] = 1'b0;
    repeat (6) cycle();

`ifdef RF_CMD_SEQ_CNT_EN
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    for (int i = 0; i < 300; i++) sendAll({2'b01, 3'(i), 7'd0, 4'(i)});
    repeat (2) cycle();
    for (int l = 0; l < NL; l++) checkVal("wr_count_sat", l, 16'(wrCount[l]), 16'd255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_cmd_seq.md
Name: rf_cmd_seq

Overview:
Command sequencer that sits directly upstream of the dual-bank register file (bank A: 8 x 4-bit, bank B: 16 x 8-bit). It accepts 16-bit commands over a valid/ready handshake and decodes each one into register-file write or read port activity. Read commands wait a programmable latency, then capture the two register-file outputs and present them with a one-cycle valid strobe. It also drives the register file's start enable.

Parameters:
READ_LAT, 1, cycles from read-address issue to output capture; legal range 0..7 (0 = combinational-read register file, 1 = registered read).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
cmd_data  input  16  command word
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
rf_start  output  1  register file enable
rf_write_reg_a  output  3  bank A write address
rf_write_data_a  output  4  bank A write data
rf_write_en_a  output  1  bank A write enable
rf_read_reg_a1  output  3  bank A read address 1
rf_read_reg_a2  output  3  bank A read address 2
rf_write_reg_b  output  4  bank B write address
rf_write_data_b  output  8  bank B write data
rf_write_en_b  output  1  bank B write enable
rf_read_reg_b  output  4  bank B read address
rf_out1  input  4  register file output 1
rf_out2  input  4  register file output 2
rd_data1  output  4  captured rf_out1
rd_data2  output  4  captured rf_out2
rd_valid  output  1  one-cycle strobe; rd_data1/rd_data2 are new

Behaviour:
- Reset (asynchronous, active-high): state goes to IDLE. Every output is 0, including rf_start, rd_valid and cmd_ready. The wait counter clears. Reset mid-command drops the in-flight command; no write enable survives reset.
- rf_start: registered. It is 0 during reset and goes to 1 on the first clk edge after rst deasserts, then stays 1.
- cmd_ready is 1 only in state IDLE and only after rf_start=1. A command is accepted on a rising edge where cmd_valid && cmd_ready. cmd_data is sampled only at acceptance.
- Decode of cmd_data[15:14]:
  - 00 NOP: no port activity; state stays IDLE.
  - 01 WRITE_A: rf_write_reg_a=[13:11], rf_write_data_a=[3:0].
  - 10 WRITE_B: rf_write_reg_b=[13:10], rf_write_data_b=[7:0].
  - 11 READ: rf_read_reg_a1=[13:11], rf_read_reg_a2=[10:8], rf_read_reg_b=[7:4].
  - Unused bits are ignored.
- FSM states: IDLE, WR, RD_WAIT.
  - IDLE -> WR when a WRITE_A or WRITE_B is accepted.
  - IDLE -> RD_WAIT when a READ is accepted.
- Write timing: the acceptance edge E0 loads the address/data registers and sets exactly one write enable. In the next cycle (state WR) that enable is 1. At edge E1 the enable clears and the state returns to IDLE. Maximum write throughput is one command per 2 cycles.
  - The write enable is high for exactly one cycle per write command.
  - Address and data outputs hold their last values after the write; only the enable drops.
- Read timing: the acceptance edge E0 loads the read addresses. The addresses hold until the next READ is accepted.
  - In RD_WAIT the counter counts edges.
  - At edge E1+READ_LAT, rd_data1<=rf_out1, rd_data2<=rf_out2, rd_valid<=1, and the state returns to IDLE.
  - rd_valid clears on the following edge unless another capture occurs on that edge (not possible by construction).
- rd_data1/rd_data2 hold their value until the next capture.
- Both write enables are never high in the same cycle.
- cmd_valid is ignored while cmd_ready=0. The producer holds its command until accepted.

Optional Feature:
Macro RF_CMD_SEQ_CNT_EN.
- Defined: adds outputs wr_count (8) and rd_count (8), both reset to 0.
  - wr_count increments on each write-enable cycle.
  - rd_count increments on each rd_valid.
  - Both saturate at 255; no wrap.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 3 cycles with cmd_valid=1 -> all outputs 0, no write enables. rf_start=1 and cmd_ready=1 one edge after rst falls.
- Writes, using a behavioural register-file model with registered read and READ_LAT=1:
  - Issue WRITE_A addr3 data F (cmd 16'h580F), WRITE_B addr4 data FF (16'h90FF), WRITE_A addr5 data 8 (16'h6808), WRITE_B addr6 data 0A (16'h980A).
  - Each command gives exactly one enable cycle with correct address/data.
  - cmd_ready is low for one cycle after each accept.
- Read-back: READ ra1=3 ra2=5 rb=6 (16'hDD60) -> rd_valid pulses once, 2 edges after acceptance, with rd_data1=F and rd_data2=8. Addresses still read 3/5/6 afterwards.
- Latency sweep: repeat the read-back with READ_LAT=0 and READ_LAT=3 -> rd_valid at E1 and E4 respectively. Check cmd_ready=0 throughout RD_WAIT.
- Backpressure/NOP: hold cmd_valid=1 with back-to-back commands -> no command is lost or duplicated. NOP (16'h0000) gives no enable and cmd_ready stays 1.
- Reset mid-read: assert rst during RD_WAIT -> rd_valid never pulses, outputs return to 0, and the next READ completes normally. With RF_CMD_SEQ_CNT_EN defined, 300 writes give wr_count=255.
